// File: rtl/vec_activate.sv
// Post-matmul stage: walks the result vector, adds bias, applies a Q8.8
// activation and streams the results into the hidden-state write port.
module vec_activate #(
  parameter int LEN_BITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [1:0]          mode,
  output logic                ready,
  output logic                done,
  output logic [LEN_BITS-1:0] rd_sel,
  input  logic [15:0]         mm_data,
  input  logic [15:0]         bias_data,
  output logic                wr_en,
  output logic [LEN_BITS-1:0] wr_sel,
  output logic [15:0]         wr_data
);

  localparam logic [1:0] ST_READY = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic [LEN_BITS-1:0] SEL_ONE  = LEN_BITS'(1);
  localparam logic [LEN_BITS-1:0] SEL_LAST = {LEN_BITS{1'b1}};

  logic [1:0]          state_r;
  logic [1:0]          mode_r;
  logic [LEN_BITS-1:0] rd_sel_r;
  logic                done_r;
  logic                s1_valid_r;
  logic [LEN_BITS-1:0] s1_index_r;
  logic signed [15:0]  s1_sum_r;
  logic                wr_en_r;
  logic [LEN_BITS-1:0] wr_sel_r;
  logic [15:0]         wr_data_r;
  logic signed [16:0]  wide_sum_s;
  logic signed [15:0]  sum_s;

  function automatic logic signed [15:0] sat16(input logic signed [16:0] v);
    if (v > 17'sd32767) begin
      return 16'sh7FFF;
    end else if (v < -17'sd32768) begin
      return 16'sh8000;
    end else begin
      return v[15:0];
    end
  endfunction

  function automatic logic [15:0] act_fn(input logic [1:0] m, input logic signed [15:0] x);
    logic signed [16:0] t;
    t = ($signed({x[15], x}) >>> 2) + 17'sd128;
    case (m)
      2'd0: begin
        if (x > 16'sd256) begin
          return 16'h0100;
        end else if (x < -16'sd256) begin
          return 16'hFF00;
        end else begin
          return x;
        end
      end
      2'd1: begin
        if (t < 17'sd0) begin
          return 16'h0000;
        end else if (t > 17'sd256) begin
          return 16'h0100;
        end else begin
          return t[15:0];
        end
      end
      2'd2: begin
        if (x < 16'sd0) begin
          return 16'h0000;
        end else begin
          return x;
        end
      end
      2'd3: return x;
      default: return x;
    endcase
  endfunction

  // Bias add widened by one bit so overflow can be saturated
  always_comb begin
    wide_sum_s = $signed({mm_data[15], mm_data}) + $signed({bias_data[15], bias_data});
    sum_s      = sat16(wide_sum_s);
  end

  // Control FSM: read index walk and completion pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_READY;
      mode_r   <= 2'd0;
      rd_sel_r <= '0;
      done_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_READY: begin
          if (start) begin
            mode_r   <= mode;
            rd_sel_r <= '0;
            state_r  <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (rd_sel_r == SEL_LAST) begin
            state_r <= ST_DRAIN;
          end else begin
            rd_sel_r <= rd_sel_r + SEL_ONE;
          end
        end
        // Stage 1 empty means the final write is already on the port
        ST_DRAIN: begin
          if (!s1_valid_r) begin
            state_r <= ST_READY;
            done_r  <= 1'b1;
          end
        end
        default: state_r <= ST_READY;
      endcase
    end
  end

  // Two-stage datapath: bias-add register, then activation into the write port
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_index_r <= '0;
      s1_sum_r   <= 16'sd0;
      wr_en_r    <= 1'b0;
      wr_sel_r   <= '0;
      wr_data_r  <= 16'h0000;
    end else begin
      s1_valid_r <= (state_r == ST_BUSY);
      s1_index_r <= rd_sel_r;
      s1_sum_r   <= sum_s;
      wr_en_r    <= s1_valid_r;
      wr_sel_r   <= s1_index_r;
      wr_data_r  <= act_fn(mode_r, s1_sum_r);
    end
  end

  assign ready   = (state_r == ST_READY);
  assign done    = done_r;
  assign rd_sel  = rd_sel_r;
  assign wr_en   = wr_en_r;
  assign wr_sel  = wr_sel_r;
  assign wr_data = wr_data_r;

endmodule
